// File: rtl/ipg_tx_sched.sv
// rtl/ipg_tx_sched.sv - two-requester IPG transmit scheduler with remote reply-buffer credits
//
// Purpose: arbitrates read-reply (requester 0) and read-request (requester 1)
// chunk streams onto inter-packet-gap transmit slots. Messages are never
// interleaved; a round-robin pointer alternates priority between message
// ends. Request messages need one remote reply-buffer credit each.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   rply_data/valid/last/ready requester 0 chunk stream (ready is combinational)
//   rreq_data/valid/last/ready requester 1 chunk stream (ready is combinational)
//   tx_slot                    an IPG slot is available this cycle
//   credit_ret                 one remote reply-buffer slot freed (pulse)
//   tx_data/valid/last/src     registered chunk towards the PHY, src 0=reply 1=request
//   credit_cnt, credit_ovf     current credits, sticky credit-return overflow
module ipg_tx_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int CREDIT_MAX = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rply_data,
  input  logic                  rply_valid,
  input  logic                  rply_last,
  output logic                  rply_ready,
  input  logic [DATA_WIDTH-1:0] rreq_data,
  input  logic                  rreq_valid,
  input  logic                  rreq_last,
  output logic                  rreq_ready,
  input  logic                  tx_slot,
  input  logic                  credit_ret,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  tx_src,
  output logic [3:0]            credit_cnt,
  output logic                  credit_ovf
);

  localparam logic [3:0] CMAX = 4'(CREDIT_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  rr;
  logic                  elig0, elig1;
  logic                  sel_any, sel;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer, consume;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           if (xfer && !sel_last) state_nxt = sel ? GRANT1 : GRANT0;
      GRANT0, GRANT1: if (xfer && sel_last)  state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Output logic: grant selection and readies. Once granted, the holder keeps
  // the grant without a credit recheck; in IDLE a request needs a credit.
  always_comb begin
    elig0   = rply_valid;
    elig1   = rreq_valid && (credit_cnt != 4'd0);
    sel_any = 1'b0;
    sel     = 1'b0;
    case (state)
      IDLE: begin
        sel_any = elig0 || elig1;
        sel     = (elig0 && elig1) ? rr : elig1;
      end
      GRANT0: begin
        sel_any = 1'b1;
        sel     = 1'b0;
      end
      GRANT1: begin
        sel_any = 1'b1;
        sel     = 1'b1;
      end
      default: begin
        sel_any = 1'b0;
        sel     = 1'b0;
      end
    endcase
    // reset gating keeps both readies low for the whole reset assertion
    rply_ready = reset && tx_slot && sel_any && !sel;
    rreq_ready = reset && tx_slot && sel_any && sel;
  end

  assign sel_valid = sel ? rreq_valid : rply_valid;
  assign sel_last  = sel ? rreq_last  : rply_last;
  assign sel_data  = sel ? rreq_data  : rply_data;
  assign xfer      = (rply_ready || rreq_ready) && sel_valid;
  // only the first chunk of a request message takes a credit
  assign consume   = xfer && sel && (state == IDLE);

  // Round-robin pointer: points at the loser of the message that just ended
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                rr <= 1'b0;
    else if (xfer && sel_last) rr <= ~sel;
  end

  // Credit counter; a return that meets a consumption cancels out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_cnt <= CMAX;
      credit_ovf <= 1'b0;
    end else if (consume && !credit_ret) begin
      credit_cnt <= credit_cnt - 4'd1;
    end else if (credit_ret && !consume) begin
      if (credit_cnt >= CMAX) credit_ovf <= 1'b1;
      else                    credit_cnt <= credit_cnt + 4'd1;
    end
  end

  // Registered PHY-side outputs; data and source hold between transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_src   <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= xfer;
      tx_last  <= xfer && sel_last;
      if (xfer) begin
        tx_src  <= sel;
        tx_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_ipg_tx_sched.sv
// tb/tb_ipg_tx_sched.sv - self-checking bench for ipg_tx_sched
module tb_ipg_tx_sched;

  localparam int   DW = 64;
  localparam logic H  = 1'b1;
  localparam logic L  = 1'b0;

  logic          clk, reset;
  logic [DW-1:0] rply_data, rreq_data, tx_data;
  logic          rply_valid, rply_last, rply_ready;
  logic          rreq_valid, rreq_last, rreq_ready;
  logic          tx_slot, credit_ret;
  logic          tx_valid, tx_last, tx_src, credit_ovf;
  logic [3:0]    credit_cnt;

  int checks = 0;
  int errors = 0;

  ipg_tx_sched #(.DATA_WIDTH(DW), .CREDIT_MAX(6)) dut (
    .clk(clk), .reset(reset),
    .rply_data(rply_data), .rply_valid(rply_valid), .rply_last(rply_last), .rply_ready(rply_ready),
    .rreq_data(rreq_data), .rreq_valid(rreq_valid), .rreq_last(rreq_last), .rreq_ready(rreq_ready),
    .tx_slot(tx_slot), .credit_ret(credit_ret),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_src(tx_src),
    .credit_cnt(credit_cnt), .credit_ovf(credit_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic slot, input logic rv, input logic rl, input logic [DW-1:0] rd,
                       input logic qv, input logic ql, input logic [DW-1:0] qd, input logic cr);
    tx_slot    = slot;
    rply_valid = rv; rply_last = rl; rply_data = rd;
    rreq_valid = qv; rreq_last = ql; rreq_data = qd;
    credit_ret = cr;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: who owns the link (-1 = nobody), whose turn it is,
  // how many remote buffers are free, and what the PHY saw last.
  // ---------------------------------------------------------------------
  int            m_owner, m_rr, m_cred;
  logic          m_ovf, m_v, m_l, m_s;
  logic [DW-1:0] m_d;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_cred = 6; m_ovf = 1'b0;
    m_v = 1'b0; m_l = 1'b0; m_s = 1'b0; m_d = '0;
  endtask

  function automatic int model_pick();
    logic want0, want1;
    if (m_owner >= 0) return m_owner;
    want0 = rply_valid;
    want1 = rreq_valid && (m_cred > 0);
    if (want0 && want1) return m_rr;
    if (want0) return 0;
    if (want1) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int   p;
    logic moved, lst, start;
    p     = model_pick();
    moved = tx_slot && (p >= 0) && ((p == 1) ? rreq_valid : rply_valid);
    start = moved && (m_owner < 0) && (p == 1);
    lst   = (p == 1) ? rreq_last : rply_last;
    if (credit_ret && !start) begin
      if (m_cred == 6) m_ovf = 1'b1;
      else             m_cred = m_cred + 1;
    end else if (start && !credit_ret) begin
      m_cred = m_cred - 1;
    end
    m_v = moved;
    m_l = moved && lst;
    if (moved) begin
      m_s = (p == 1);
      m_d = (p == 1) ? rreq_data : rply_data;
      if (lst) begin
        m_owner = -1;
        m_rr    = 1 - p;
      end else begin
        m_owner = p;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(L, L, L, 64'h0, L, L, 64'h0, L);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table: one record per cycle, inputs then expectations
  // (readies before the edge, registered outputs and credits after it).
  // ---------------------------------------------------------------------
  typedef struct {
    logic          slot, rv, rl, qv, ql, cr;
    logic [DW-1:0] rd, qd;
    logic          e_r0, e_r1, e_v, e_l, e_s;
    logic [DW-1:0] e_d;
    logic [3:0]    e_c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic slot, input logic rv, input logic rl, input logic [DW-1:0] rd,
                              input logic qv, input logic ql, input logic [DW-1:0] qd, input logic cr,
                              input logic e0, input logic e1, input logic ev, input logic el,
                              input logic es, input logic [DW-1:0] ed, input logic [3:0] ec);
    vec_t v;
    v.slot = slot; v.rv = rv; v.rl = rl; v.rd = rd;
    v.qv = qv; v.ql = ql; v.qd = qd; v.cr = cr;
    v.e_r0 = e0; v.e_r1 = e1; v.e_v = ev; v.e_l = el; v.e_s = es; v.e_d = ed; v.e_c = ec;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    drive(H, H, H, 64'h5, H, H, 64'h6, L);
    #2;
    // reset state, with both requesters pushing and a slot offered
    reset = 1'b0;
    #1;
    chk1("rst_rply_ready", rply_ready, L);
    chk1("rst_rreq_ready", rreq_ready, L);
    chk1("rst_tx_valid",   tx_valid,   L);
    chk1("rst_tx_last",    tx_last,    L);
    chk1("rst_tx_src",     tx_src,     L);
    chkw("rst_tx_data",    tx_data,    64'h0);
    chk4("rst_credit_cnt", credit_cnt, 4'd6);
    chk1("rst_credit_ovf", credit_ovf, L);

    // contention: rr=0 so R0a,R0b then R1a,R1b; rr back to 0
    tbl.push_back(mk(H, H, L, 64'hA0A, H, L, 64'hB1A, L,  H, L,  H, L, L, 64'hA0A, 4'd6));
    tbl.push_back(mk(H, H, H, 64'hA0B, H, L, 64'hB1A, L,  H, L,  H, H, L, 64'hA0B, 4'd6));
    tbl.push_back(mk(H, H, L, 64'hEEE, H, L, 64'hB1A, L,  L, H,  H, L, H, 64'hB1A, 4'd5));
    tbl.push_back(mk(H, H, L, 64'hEEE, H, H, 64'hB1B, L,  L, H,  H, H, H, 64'hB1B, 4'd5));
    // reply-only three chunks, slot always on
    tbl.push_back(mk(H, H, L, 64'hA1, L, L, 64'h0, L,  H, L,  H, L, L, 64'hA1, 4'd5));
    tbl.push_back(mk(H, H, L, 64'hA2, L, L, 64'h0, L,  H, L,  H, L, L, 64'hA2, 4'd5));
    tbl.push_back(mk(H, H, H, 64'hA3, L, L, 64'h0, L,  H, L,  H, H, L, 64'hA3, 4'd5));
    // slot gating 1,0,1,0,1 over a three-chunk reply
    tbl.push_back(mk(H, H, L, 64'hC1, L, L, 64'h0, L,  H, L,  H, L, L, 64'hC1, 4'd5));
    tbl.push_back(mk(L, H, L, 64'hC2, L, L, 64'h0, L,  L, L,  L, L, L, 64'hC1, 4'd5));
    tbl.push_back(mk(H, H, L, 64'hC2, L, L, 64'h0, L,  H, L,  H, L, L, 64'hC2, 4'd5));
    tbl.push_back(mk(L, H, H, 64'hC3, L, L, 64'h0, L,  L, L,  L, L, L, 64'hC2, 4'd5));
    tbl.push_back(mk(H, H, H, 64'hC3, L, L, 64'h0, L,  H, L,  H, H, L, 64'hC3, 4'd5));
    tbl.push_back(mk(H, L, L, 64'h0,  L, L, 64'h0, L,  L, L,  L, L, L, 64'hC3, 4'd5));
    // request valid drops mid-message: grant held, reply not admitted
    tbl.push_back(mk(H, L, L, 64'h0,  H, L, 64'hD1, L,  L, H,  H, L, H, 64'hD1, 4'd4));
    tbl.push_back(mk(H, H, L, 64'hE1, L, L, 64'hD2, L,  L, H,  L, L, L, 64'hD1, 4'd4));
    tbl.push_back(mk(H, H, L, 64'hE1, H, H, 64'hD2, L,  L, H,  H, H, H, 64'hD2, 4'd4));
    // lone credit return, then return coinciding with a request start
    tbl.push_back(mk(H, L, L, 64'h0,  L, L, 64'h0,  H,  L, L,  L, L, L, 64'hD2, 4'd5));
    tbl.push_back(mk(H, L, L, 64'h0,  H, H, 64'hF1, H,  L, H,  H, H, H, 64'hF1, 4'd5));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].slot, tbl[i].rv, tbl[i].rl, tbl[i].rd, tbl[i].qv, tbl[i].ql, tbl[i].qd, tbl[i].cr);
      #1;
      chk1($sformatf("tbl%0d_rply_ready", i), rply_ready, tbl[i].e_r0);
      chk1($sformatf("tbl%0d_rreq_ready", i), rreq_ready, tbl[i].e_r1);
      @(posedge clk);
      #1;
      chk1($sformatf("tbl%0d_tx_valid", i), tx_valid, tbl[i].e_v);
      chk1($sformatf("tbl%0d_tx_last", i),  tx_last,  tbl[i].e_l);
      if (tbl[i].e_v) chk1($sformatf("tbl%0d_tx_src", i), tx_src, tbl[i].e_s);
      chkw($sformatf("tbl%0d_tx_data", i),    tx_data,    tbl[i].e_d);
      chk4($sformatf("tbl%0d_credit_cnt", i), credit_cnt, tbl[i].e_c);
      chk1($sformatf("tbl%0d_credit_ovf", i), credit_ovf, L);
    end

    // credit exhaustion: seven single-chunk requests, six go out
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(H, L, L, 64'h0, H, H, 64'h70 + 64'(i), L);
      #1;
      chk1($sformatf("exh%0d_rreq_ready", i), rreq_ready, i < 6);
      @(posedge clk);
      #1;
      chk1($sformatf("exh%0d_tx_valid", i), tx_valid, i < 6);
      chk4($sformatf("exh%0d_credit_cnt", i), credit_cnt, (i < 6) ? 4'(5 - i) : 4'd0);
    end
    drive(H, L, L, 64'h0, H, H, 64'h77, H);
    #1;
    chk1("exh_ret_rreq_ready", rreq_ready, L);
    @(posedge clk);
    #1;
    chk4("exh_ret_credit_cnt", credit_cnt, 4'd1);
    drive(H, L, L, 64'h0, H, H, 64'h77, L);
    #1;
    chk1("exh_7th_rreq_ready", rreq_ready, H);
    @(posedge clk);
    #1;
    chk1("exh_7th_tx_valid",   tx_valid,   H);
    chkw("exh_7th_tx_data",    tx_data,    64'h77);
    chk4("exh_7th_credit_cnt", credit_cnt, 4'd0);

    // credit return at full credits overflows and sticks
    do_reset();
    drive(H, L, L, 64'h0, L, L, 64'h0, H);
    @(posedge clk);
    #1;
    chk4("ovf_credit_cnt", credit_cnt, 4'd6);
    chk1("ovf_credit_ovf", credit_ovf, H);
    drive(H, L, L, 64'h0, L, L, 64'h0, L);
    @(posedge clk);
    #1;
    chk1("ovf_sticky", credit_ovf, H);
    do_reset();
    drive(H, L, L, 64'h0, H, H, 64'h99, H);
    @(posedge clk);
    #1;
    chk1("ovf_coinc_tx_valid",   tx_valid,   H);
    chk4("ovf_coinc_credit_cnt", credit_cnt, 4'd6);
    chk1("ovf_coinc_credit_ovf", credit_ovf, L);

    // reset in the middle of a three-chunk request
    do_reset();
    drive(H, L, L, 64'h0, H, L, 64'h11, L);
    @(posedge clk);
    #1;
    chk4("mid_credit_before", credit_cnt, 4'd5);
    drive(H, H, L, 64'h21, H, L, 64'h12, L);
    #1;
    reset = 1'b0;
    #1;
    chk1("mid_tx_valid",   tx_valid,   L);
    chk1("mid_tx_src",     tx_src,     L);
    chkw("mid_tx_data",    tx_data,    64'h0);
    chk4("mid_credit_cnt", credit_cnt, 4'd6);
    chk1("mid_rreq_ready", rreq_ready, L);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(H, H, H, 64'h21, L, L, 64'h0, L);
    #1;
    chk1("mid_after_rply_ready", rply_ready, H);
    chk1("mid_after_rreq_ready", rreq_ready, L);
    @(posedge clk);
    #1;
    chk1("mid_after_tx_valid", tx_valid, H);
    chk1("mid_after_tx_src",   tx_src,   L);
    chkw("mid_after_tx_data",  tx_data,  64'h21);

    // randomized traffic against the model; second half returns credits often
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, {$urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, {$urandom, $urandom},
            (c < 1500) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0));
      #1;
      chk1("rnd_rply_ready", rply_ready, tx_slot && (model_pick() == 0));
      chk1("rnd_rreq_ready", rreq_ready, tx_slot && (model_pick() == 1));
      model_step();
      @(posedge clk);
      #1;
      chk1("rnd_tx_valid", tx_valid, m_v);
      chk1("rnd_tx_last",  tx_last,  m_l);
      if (m_v) chk1("rnd_tx_src", tx_src, m_s);
      chkw("rnd_tx_data",    tx_data,    m_d);
      chk4("rnd_credit_cnt", credit_cnt, 4'(m_cred));
      chk1("rnd_credit_ovf", credit_ovf, m_ovf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
